// File: rtl/ahbl_apb3_bridge.sv
// AHB-Lite slave that turns each accepted transfer into one APB3 access.
// All outputs are registered; bad HSIZE, PSLVERR and PREADY timeout give a two-cycle ERROR.
module ahbl_apb3_bridge #(
  parameter int APB_AWIDTH = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_AWIDTH-1:0] PADDR,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LATCH, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2
  } state_t;

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                state, next;
  logic [APB_AWIDTH-1:0] addr_q;
  logic                  write_q;
  logic [7:0]            count;
  logic                  acc, size_ok, take;

  assign acc     = HSEL & HREADY & ((HTRANS == 2'b10) || (HTRANS == 2'b11));
  assign size_ok = (HSIZE <= 3'b010);
  assign take    = acc & ((state == ST_IDLE) || (state == ST_ERR2));

  always_comb begin
    next = state;
    case (state)
      ST_IDLE:   if (take) next = size_ok ? ST_LATCH : ST_ERR1;
      ST_LATCH:  next = ST_SETUP;
      ST_SETUP:  next = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY)
          next = PSLVERR ? ST_ERR1 : ST_IDLE;
        else if (TO_EN && (count == TO_LAST))
          next = ST_ERR1;
      end
      ST_ERR1:   next = ST_ERR2;
      ST_ERR2:   next = take ? (size_ok ? ST_LATCH : ST_ERR1) : ST_IDLE;
      default:   next = ST_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they are flops, not logic.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      count     <= 8'd0;
    end else begin
      state     <= next;
      HREADYOUT <= (next == ST_IDLE) || (next == ST_ERR2);
      HRESP     <= (next == ST_ERR1) || (next == ST_ERR2);
      PSEL      <= (next == ST_SETUP) || (next == ST_ACCESS);
      PENABLE   <= (next == ST_ACCESS);
      count     <= ((state == ST_ACCESS) && (next == ST_ACCESS)) ? count + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= 32'd0;
      HRDATA  <= 32'd0;
    end else begin
      if (take) begin
        addr_q  <= HADDR[APB_AWIDTH-1:0];
        write_q <= HWRITE;
      end
      if (state == ST_LATCH) begin
        PADDR  <= addr_q;
        PWRITE <= write_q;
        if (write_q)
          PWDATA <= HWDATA;
      end
      if ((state == ST_ACCESS) && PREADY && !PSLVERR && !write_q)
        HRDATA <= PRDATA;
    end
  end

endmodule

// File: tb/tb_ahbl_apb3_bridge.sv
// Directed bench for ahbl_apb3_bridge: a transfer-level model queues the expected
// per-cycle outputs and one negedge process compares them against the DUT.
module tb_ahbl_apb3_bridge;

  localparam int TO_N = 4;

  logic        HCLK = 1'b0;
  logic        HRESETN;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  always #5 HCLK = ~HCLK;

  ahbl_apb3_bridge #(.APB_AWIDTH(32), .TIMEOUT(TO_N)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADYOUT),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic        rdy, resp, psel, pen, pwrite;
    logic [31:0] hrdata, paddr, pwdata;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t_addr = 0;
  int          pen_cnt = 0;
  logic        psel_seen = 1'b0;
  logic        check_en = 1'b0;
  logic        pending_err2 = 1'b0;
  logic [31:0] hrdata_m = 0, paddr_m = 0, pwdata_m = 0;
  logic        pwrite_m = 1'b0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, want);
    end
  endtask

  task automatic push_exp(input logic rdy, input logic resp, input logic psel, input logic pen);
    exp_t e;
    e.rdy = rdy; e.resp = resp; e.psel = psel; e.pen = pen;
    e.hrdata = hrdata_m; e.paddr = paddr_m; e.pwdata = pwdata_m; e.pwrite = pwrite_m;
    exp_q.push_back(e);
  endtask

  always @(negedge HCLK) begin
    if (PENABLE) pen_cnt++;
    if (PSEL) psel_seen = 1'b1;
    if (check_en && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("hreadyout", HREADYOUT, e.rdy);
      chk("hresp", HRESP, e.resp);
      chk("psel", PSEL, e.psel);
      chk("penable", PENABLE, e.pen);
      chk("hrdata", HRDATA, e.hrdata);
      chk("paddr", PADDR, e.paddr);
      chk("pwrite", PWRITE, e.pwrite);
      chk("pwdata", PWDATA, e.pwdata);
    end
  end

  task automatic idle_cycle(input logic [1:0] trans, input logic sel);
    @(posedge HCLK); #1;
    HSEL = sel; HTRANS = trans; HADDR = 32'hFFFF_FFF0; HWRITE = 1'b1; HSIZE = 3'b000;
    PREADY = 1'b1; PSLVERR = 1'b0;
    push_exp(1'b1, pending_err2, 1'b0, 1'b0);
    pending_err2 = 1'b0;
  endtask

  // One AHB transfer; returns during its last ACCESS cycle (or its ERR1 cycle).
  task automatic apply_xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                            input logic [31:0] d, input int waits, input logic err,
                            input logic tmo, input logic [31:0] rd);
    int n_acc;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = sz;
    PREADY = 1'b1; PSLVERR = 1'b1;
    t_addr = cyc;
    push_exp(1'b1, pending_err2, 1'b0, 1'b0);
    pending_err2 = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = ~a; HWRITE = ~wr; HSIZE = 3'b111; HWDATA = d;
    if (sz > 3'b010) begin
      push_exp(1'b0, 1'b1, 1'b0, 1'b0);
      pending_err2 = 1'b1;
      return;
    end
    push_exp(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge HCLK); #1;
    HWDATA = ~d;
    paddr_m = a; pwrite_m = wr;
    if (wr) pwdata_m = d;
    push_exp(1'b0, 1'b0, 1'b1, 1'b0);
    n_acc = tmo ? TO_N : waits + 1;
    for (int i = 0; i < n_acc; i++) begin
      @(posedge HCLK); #1;
      if (!tmo && i == waits) begin
        PREADY = 1'b1; PSLVERR = err; PRDATA = rd;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = ~rd;
      end
      push_exp(1'b0, 1'b0, 1'b1, 1'b1);
    end
    if (err || tmo) begin
      @(posedge HCLK); #1;
      PREADY = 1'b1; PSLVERR = 1'b1;
      push_exp(1'b0, 1'b1, 1'b0, 1'b0);
      pending_err2 = 1'b1;
    end else if (!wr) begin
      hrdata_m = rd;
    end
  endtask

  task automatic model_reset();
    hrdata_m = 0; paddr_m = 0; pwdata_m = 0; pwrite_m = 1'b0; pending_err2 = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hreadyout"}, HREADYOUT, 1'b1);
    chk({tag, "_hresp"}, HRESP, 1'b0);
    chk({tag, "_hrdata"}, HRDATA, 32'h0);
    chk({tag, "_psel"}, PSEL, 1'b0);
    chk({tag, "_penable"}, PENABLE, 1'b0);
    chk({tag, "_pwrite"}, PWRITE, 1'b0);
    chk({tag, "_paddr"}, PADDR, 32'h0);
    chk({tag, "_pwdata"}, PWDATA, 32'h0);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    HRESETN = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HADDR = 0; HWRITE = 1'b0; HSIZE = 3'b000;
    HWDATA = 0; PRDATA = 0; PREADY = 1'b1; PSLVERR = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETN = 1'b1;
    @(posedge HCLK); #1;
    check_reset_outputs("reset");
    check_en = 1'b1;

    // Zero-wait write; HREADYOUT back at T+4
    apply_xfer(32'h0000_0010, 1'b1, 3'b010, 32'hA5A5_5A5A, 0, 1'b0, 1'b0, 32'h0);
    chk("wr_paddr", PADDR, 32'h0000_0010);
    chk("wr_pwdata", PWDATA, 32'hA5A5_5A5A);
    chk("wr_pwrite", PWRITE, 1'b1);
    idle_cycle(2'b00, 1'b0);
    chk("wr_latency", cyc - t_addr, 4);
    chk("wr_done_rdy", HREADYOUT, 1'b1);

    // Read with three PREADY-low cycles; data at T+7
    apply_xfer(32'h0000_0004, 1'b0, 3'b010, 32'h0, 3, 1'b0, 1'b0, 32'h1234_5678);
    idle_cycle(2'b00, 1'b0);
    chk("rd_latency", cyc - t_addr, 7);
    chk("rd_hrdata", HRDATA, 32'h1234_5678);

    // Errored read keeps HRDATA; next NONSEQ accepted in ERR2
    apply_xfer(32'h0000_0008, 1'b0, 3'b010, 32'h0, 0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("err1_hresp", HRESP, 1'b1);
    chk("err1_hreadyout", HREADYOUT, 1'b0);
    chk("err_hrdata_kept", HRDATA, 32'h1234_5678);
    apply_xfer(32'h0000_000C, 1'b0, 3'b001, 32'h0, 1, 1'b0, 1'b0, 32'hCAFE_F00D);
    idle_cycle(2'b00, 1'b0);
    chk("after_err_hrdata", HRDATA, 32'hCAFE_F00D);

    // PREADY timeout after exactly TO_N ACCESS cycles
    pen_cnt = 0;
    apply_xfer(32'h0000_0040, 1'b1, 3'b010, 32'h0BAD_0BAD, 0, 1'b0, 1'b1, 32'h0);
    idle_cycle(2'b00, 1'b0);
    chk("timeout_penable_cycles", pen_cnt, TO_N);
    apply_xfer(32'h0000_0044, 1'b1, 3'b000, 32'h1111_2222, 2, 1'b0, 1'b0, 32'h0);
    idle_cycle(2'b00, 1'b0);

    // Oversized HSIZE and non-transfer cycles never reach APB
    psel_seen = 1'b0;
    apply_xfer(32'h0000_0050, 1'b1, 3'b011, 32'h7777_8888, 0, 1'b0, 1'b0, 32'h0);
    idle_cycle(2'b01, 1'b1);
    idle_cycle(2'b00, 1'b1);
    idle_cycle(2'b10, 1'b0);
    apply_xfer(32'h0000_0054, 1'b0, 3'b100, 32'h0, 0, 1'b0, 1'b0, 32'h0);
    idle_cycle(2'b01, 1'b1);
    idle_cycle(2'b00, 1'b0);
    chk("bad_size_no_psel", psel_seen, 1'b0);

    // Asynchronous reset in the middle of an ACCESS
    @(negedge HCLK); #1;
    check_en = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0030; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h5555_AAAA;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    PREADY = 1'b0;
    chk("pre_reset_penable", PENABLE, 1'b1);
    #2 HRESETN = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRESETN = 1'b1;
    model_reset();
    check_en = 1'b1;
    idle_cycle(2'b00, 1'b0);
    apply_xfer(32'h0000_0020, 1'b1, 3'b010, 32'h600D_F00D, 0, 1'b0, 1'b0, 32'h0);
    idle_cycle(2'b00, 1'b0);
    chk("post_reset_latency", cyc - t_addr, 4);
    chk("post_reset_pwdata", PWDATA, 32'h600D_F00D);
    chk("post_reset_paddr", PADDR, 32'h0000_0020);

    @(negedge HCLK); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
